uart_text_buffer: RTL
=====================

Name: uart_text_buffer

Overview:
- Upstream feeder for the VGA character generator: accepts bytes from the UART receiver (valid strobe plus byte) and maintains a one-line text buffer of ASCII codes with a write cursor.
- The renderer reads one character per request through a registered read port. It uses the returned code to address the character ROM.
- Handles printable characters, backspace and carriage-return (clear), and runs an automatic clear sweep after reset.

Parameters:
- DEPTH, 32, number of character cells in the line buffer (power of two).
- ADDR_W, 5, cell address width; equals log2(DEPTH).
- WRAP, 1, 1 = cursor wraps to 0 after the last cell; 0 = cursor saturates at DEPTH-1, and further printables overwrite that cell.
- BLANK, 8'h20, code written by clear and by backspace.

Ports:
- clk  in  1  system clock; same clock as the UART receiver and the renderer.
- rst_n  in  1  asynchronous active-low reset.
- i_RX_DV  in  1  one-cycle strobe: i_RX_Byte valid.
- i_RX_Byte  in  8  received byte.
- i_rd_addr  in  ADDR_W  renderer read address (cell index).
- o_rd_ascii  out  8  contents of cell i_rd_addr, registered, 1-cycle latency.
- o_rd_cursor  out  1  1 when the registered read address equals the cursor; aligned with o_rd_ascii.
- o_cursor  out  ADDR_W  current write cursor.
- o_busy  out  1  clear sweep in progress.
- o_overflow  out  1  sticky: a byte was dropped.
- i_clr_overflow  in  1  synchronous clear of o_overflow.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to S_CLEAR, sweep index = 0, cursor = 0, pending register empty.
  - Outputs: o_rd_ascii=8'h00, o_rd_cursor=0, o_cursor=0, o_busy=1, o_overflow=0.
  - Buffer storage itself is not reset; it is initialised by the sweep.
- S_CLEAR:
  - Writes BLANK to the cell at the sweep index each cycle; index increments.
  - After writing cell DEPTH-1, goes to S_IDLE. The sweep takes exactly DEPTH cycles; o_busy is 1 throughout and falls on the cycle S_IDLE is entered.
  - A byte arriving during S_CLEAR is captured in a 1-deep pending register.
  - A second byte arriving while pending is full is dropped and sets o_overflow.
- S_IDLE: processes the byte in this cycle. Source is the pending register if full (pending is drained first), else i_RX_DV/i_RX_Byte.
  - If pending is being drained and i_RX_DV=1 in the same cycle, the new byte loads into pending; it is not dropped.
  - 0x20..0x7E: write the byte at the cursor, then advance the cursor.
    - Cursor < DEPTH-1: cursor+1.
    - Cursor at DEPTH-1: 0 if WRAP=1, stays at DEPTH-1 if WRAP=0.
  - 0x08 (backspace):
    - Cursor > 0: cursor-1, and BLANK is written at the new cursor.
    - Cursor = 0: no-op.
  - 0x0D (CR): cursor=0, sweep index=0, go to S_CLEAR (o_busy=1 next cycle).
  - All other codes (including 0x0A) are ignored with no state change.
- Read port:
  - o_rd_ascii is mem[i_rd_addr] sampled at the clock edge.
  - If the same cell is written in the same cycle, the read returns the old value; the new value is visible on the next read.
  - o_rd_cursor compares the registered address with the cursor value before that edge's update.
- Overflow:
  - o_overflow is set only by a drop and held until i_clr_overflow=1.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-sweep or mid-write: the async reset aborts the operation; the sweep restarts from index 0 after reset is released.
- Widths:
  - Cursor and sweep index are ADDR_W bits.
  - Wrap uses natural modulo arithmetic when WRAP=1; an explicit compare is used when WRAP=0.

Decomposition:
- Shared package (vga_text_pkg): ASCII_BS=8'h08, ASCII_CR=8'h0D, ASCII_SPACE=8'h20, ASCII_TILDE=8'h7E, and the state enum {S_CLEAR, S_IDLE}.
- One sub-module: text_line_ram. Simple dual-port, one write port and one registered read port, DEPTH x 8, read-before-write; infers block or distributed RAM.
- The FSM, cursor, pending register and overflow logic stay in the top module.

Test Plan:
- Release reset, no input -> o_busy=1 for exactly 32 cycles; then reading all addresses returns 8'h20; o_cursor=0.
- Strobe "H","i" (8'h48, 8'h69) after busy falls -> read addr0=8'h48, addr1=8'h69; o_cursor=2; o_rd_cursor=1 only when reading addr2.
- Write 33 printables 'A'..: WRAP=1 -> cell0 holds the 33rd char and o_cursor=1; WRAP=0 -> cell31 holds the last char and o_cursor=31.
- From cursor=2, send 0x08 twice then 0x08 again -> cursor 1, 0, 0; cells 0 and 1 read 8'h20; the third backspace changes nothing.
- Send 0x0D, then two bytes during the sweep -> first byte written at cell0 after the sweep, second dropped, o_overflow=1. Then i_clr_overflow -> o_overflow=0.
- Assert rst_n=0 at sweep index 10 with a byte pending -> all outputs return to reset values immediately, pending is discarded, and the sweep restarts for the full 32 cycles.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared definitions for the UART-to-VGA text path: ASCII control codes
// recognised by the line buffer and the buffer controller state encoding.
package vga_text_pkg;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_e;

endpackage

// File: rtl/text_line_ram.sv
// Simple dual-port line storage, DEPTH x 8, read-before-write.
// Ports:
//   clk, rst_n          clock / async active-low reset (read register only)
//   we_i, waddr_i,
//   wdata_i             write port
//   raddr_i             read address
//   rdata_o             registered read data, 1-cycle latency
module text_line_ram #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Storage is left unreset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-blocking read of the old contents gives read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_text_buffer.sv
// One-line text buffer fed by the UART receiver, read by the VGA renderer.
// Ports:
//   clk, rst_n           clock / async active-low reset
//   i_RX_DV, i_RX_Byte   received byte strobe and data
//   i_rd_addr            renderer cell index
//   o_rd_ascii           cell contents, 1-cycle latency
//   o_rd_cursor          registered read address matched the cursor
//   o_cursor             current write cursor
//   o_busy               clear sweep in progress
//   o_overflow           sticky byte-dropped flag
//   i_clr_overflow       clears o_overflow
module uart_text_buffer
    import vga_text_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter bit          WRAP   = 1'b1,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_RX_DV,
    input  logic [7:0]        i_RX_Byte,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_ascii,
    output logic              o_rd_cursor,
    output logic [ADDR_W-1:0] o_cursor,
    output logic              o_busy,
    output logic              o_overflow,
    input  logic              i_clr_overflow
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    logic              pend_valid_q, pend_valid_d;
    logic [7:0]        pend_byte_q, pend_byte_d;
    logic              overflow_q, overflow_d;
    logic              busy_q;
    logic              rd_cursor_q;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;
    logic              byte_vld;
    logic [7:0]        byte_val;
    logic              ovf_set;
    logic [ADDR_W-1:0] cursor_inc;

    // Cursor advance: free-running modulo when wrapping, else saturate.
    always_comb begin
        if (WRAP) begin
            cursor_inc = cursor_q + ADDR_W'(1);
        end else if (cursor_q == LAST) begin
            cursor_inc = cursor_q;
        end else begin
            cursor_inc = cursor_q + ADDR_W'(1);
        end
    end

    // Next-state, pending register and RAM write control.
    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        cursor_d     = cursor_q;
        pend_valid_d = pend_valid_q;
        pend_byte_d  = pend_byte_q;
        ovf_set      = 1'b0;
        we           = 1'b0;
        waddr        = cursor_q;
        wdata        = BLANK;
        byte_vld     = 1'b0;
        byte_val     = i_RX_Byte;

        case (state_q)
            S_CLEAR: begin
                we      = 1'b1;
                waddr   = sweep_q;
                wdata   = BLANK;
                sweep_d = sweep_q + ADDR_W'(1);
                if (sweep_q == LAST) begin
                    state_d = S_IDLE;
                end
                if (i_RX_DV) begin
                    if (!pend_valid_q) begin
                        pend_valid_d = 1'b1;
                        pend_byte_d  = i_RX_Byte;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
            end

            S_IDLE: begin
                // Pending byte goes first; a simultaneous arrival refills it.
                if (pend_valid_q) begin
                    byte_vld     = 1'b1;
                    byte_val     = pend_byte_q;
                    pend_valid_d = i_RX_DV;
                    if (i_RX_DV) begin
                        pend_byte_d = i_RX_Byte;
                    end
                end else begin
                    byte_vld = i_RX_DV;
                end

                if (byte_vld) begin
                    if (byte_val >= ASCII_SPACE && byte_val <= ASCII_TILDE) begin
                        we       = 1'b1;
                        waddr    = cursor_q;
                        wdata    = byte_val;
                        cursor_d = cursor_inc;
                    end else if (byte_val == ASCII_BS) begin
                        if (cursor_q != '0) begin
                            cursor_d = cursor_q - ADDR_W'(1);
                            we       = 1'b1;
                            waddr    = cursor_q - ADDR_W'(1);
                            wdata    = BLANK;
                        end
                    end else if (byte_val == ASCII_CR) begin
                        cursor_d = '0;
                        sweep_d  = '0;
                        state_d  = S_CLEAR;
                    end
                end
            end

            default: begin
                state_d = S_CLEAR;
                sweep_d = '0;
            end
        endcase
    end

    // Sticky overflow; a drop in the same cycle as a clear wins.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (i_clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_CLEAR;
            sweep_q      <= '0;
            cursor_q     <= '0;
            pend_valid_q <= 1'b0;
            pend_byte_q  <= 8'h00;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b1;
            rd_cursor_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            cursor_q     <= cursor_d;
            pend_valid_q <= pend_valid_d;
            pend_byte_q  <= pend_byte_d;
            overflow_q   <= overflow_d;
            busy_q       <= (state_d == S_CLEAR);
            // Compared against the pre-update cursor, aligned with read data.
            rd_cursor_q  <= (i_rd_addr == cursor_q);
        end
    end

    text_line_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (i_rd_addr),
        .rdata_o (o_rd_ascii)
    );

    assign o_rd_cursor = rd_cursor_q;
    assign o_cursor    = cursor_q;
    assign o_busy      = busy_q;
    assign o_overflow  = overflow_q;

endmodule
